myproject_mul_share_arb: RTL
============================

MYPROJECT_MUL_SHARE_ARB -- requirements
Module: myproject_mul_share_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 Parameter DIN0_W, default 3, unsigned operand-0 width.
REQ-003 Parameter DIN1_W, default 8, unsigned operand-1 width.
REQ-004 Parameter DOUT_W, default 10, result width.
REQ-005 ap_clk  in  1  sole clock; all logic rising-edge.
REQ-006 ap_rst_n  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  N_REQ  per-requester operand valid.
REQ-008 req_ready  out  N_REQ  per-requester accept; one-hot or zero.
REQ-009 req_din0  in  N_REQ*DIN0_W  packed operand 0; requester i at bits [i*DIN0_W +: DIN0_W].
REQ-010 req_din1  in  N_REQ*DIN1_W  packed operand 1, same packing.
REQ-011 res_valid  out  1  result valid.
REQ-012 res_ready  in  1  downstream accept.
REQ-013 res_data  out  DOUT_W  product.
REQ-014 res_id  out  clog2(N_REQ)  index of the originating requester.
REQ-015 busy  out  1  high while the result register holds data.
REQ-016 op_count  out  32  number of completed result transfers.

Function
REQ-017 Transfer on a request port occurs when req_valid[i] and req_ready[i] are both high; transfer on the result port occurs when res_valid and res_ready are both high.
REQ-018 Product = unsigned din0 * unsigned din1, zero-extended to DIN0_W+DIN1_W bits and truncated to the low DOUT_W bits; no saturation.
REQ-019 FSM states: S_EMPTY (result register empty) and S_FULL (result register holding a result).
REQ-020 Transitions: S_EMPTY -> S_FULL on a grant. S_FULL -> S_EMPTY on a result transfer with no grant. S_FULL remains S_FULL on a result transfer with a grant (back-to-back) or when res_ready is low.
REQ-021 Grant is permitted when the state is S_EMPTY, or S_FULL with res_ready high.
REQ-022 req_ready is combinational from req_valid, the state, res_ready and the RR pointer.
REQ-023 Arbitration is round-robin: the search starts at index ptr and selects the first i with req_valid[i] high, modulo N_REQ.
REQ-024 ptr is updated to (granted index + 1) mod N_REQ on each grant and does not change otherwise.
REQ-025 Latency is 1 cycle: a grant in cycle t presents res_valid, res_data and res_id in cycle t+1.
REQ-026 Sustained throughput is one result per cycle while res_ready is high.
REQ-027 res_data and res_id are stable while res_valid is high and res_ready is low.
REQ-028 Requesters that are not granted see req_ready low; they are required to hold valid and data (AXI-Stream rule).
REQ-029 busy equals (state == S_FULL).
REQ-030 op_count increments by 1 per result transfer and wraps from 2^32-1 to 0.
REQ-031 With no req_valid high and no result transfer, the block holds all state.

Reset
REQ-032 While ap_rst_n is low at a clock edge: state becomes S_EMPTY, ptr 0, res_valid 0, res_data 0, res_id 0, op_count 0.
REQ-033 During reset req_ready is all-zero.
REQ-034 A reset asserted while in S_FULL discards the held result, with no transfer counted.
REQ-035 The first grant is permitted in the cycle after ap_rst_n is sampled high.

Structure
REQ-036 A shared package holds the FSM state enum and the ID-width function clog2.
REQ-037 The round-robin select is the sub-module myproject_mul_share_rr: inputs req and ptr, outputs one-hot grant and a found flag; purely combinational.
REQ-038 The multiply is a single combinational operator instance feeding the result register; no other multiplier is inferred.

Verification
REQ-039 Reset: hold ap_rst_n low 3 cycles with all req_valid=1111 -> req_ready=0000, res_valid=0, op_count=0; first grant to requester 0 one cycle after release.
REQ-040 Single op: requester 2 drives din0=5, din1=200 -> next cycle res_valid=1, res_data=1000, res_id=2.
REQ-041 Truncation: din0=7, din1=255 -> res_data=761 (1785 mod 1024).
REQ-042 Fairness: all four valid continuously, res_ready=1 -> grant order 0,1,2,3,0,... at one grant per cycle; op_count=8 after 8 transfers.
REQ-043 Backpressure: res_ready=0 for 5 cycles with result id=1 held -> res_data/res_id stable, req_ready=0000, busy=1; res_ready=1 -> transfer plus same-cycle grant to requester 2.
REQ-044 Mid-operation reset: in S_FULL with res_ready=0, pulse ap_rst_n low 1 cycle -> res_valid=0, op_count unchanged at its reset value 0, ptr=0.

Source files
------------

// File: rtl/myproject_mul_share_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
package myproject_mul_share_arb_pkg;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam int unsigned CNT_W = 32;

    // Ceiling log2, used for requester-index widths; returns at least 1 for n >= 2.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (((n - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/myproject_mul_share_rr.sv
// Combinational round-robin select: first asserted request at or after ptr, modulo N_REQ.
module myproject_mul_share_rr
    import myproject_mul_share_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic             found
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/myproject_mul_share_arb.sv
// N requesters share one unsigned multiplier through a round-robin arbiter
// and a single-entry result register with valid/ready handshakes.
module myproject_mul_share_arb
    import myproject_mul_share_arb_pkg::*;
#(
    parameter  int unsigned N_REQ  = 4,
    parameter  int unsigned DIN0_W = 3,
    parameter  int unsigned DIN1_W = 8,
    parameter  int unsigned DOUT_W = 10,
    localparam int unsigned ID_W   = clog2(N_REQ)
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DIN0_W-1:0]   req_din0,
    input  logic [N_REQ*DIN1_W-1:0]   req_din1,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DOUT_W-1:0]         res_data,
    output logic [ID_W-1:0]           res_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          op_count
);

    localparam int unsigned PROD_W = DIN0_W + DIN1_W;

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     ptr_next;
    logic [ID_W-1:0]     gnt_idx;
    logic [N_REQ-1:0]    rr_grant;
    logic                rr_found;
    logic                can_grant;
    logic                grant;
    logic                xfer;
    logic [DIN0_W-1:0]   sel_din0;
    logic [DIN1_W-1:0]   sel_din1;
    logic [DOUT_W-1:0]   product;

    myproject_mul_share_rr #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (rr_grant),
        .found (rr_found)
    );

    // The result register can take a new product when empty or draining this cycle.
    assign xfer      = res_valid && res_ready;
    assign can_grant = ap_rst_n && ((state == S_EMPTY) || res_ready);
    assign grant     = can_grant && rr_found;
    assign req_ready = grant ? rr_grant : '0;

    // One-hot grant drives both the operand mux and the granted index.
    always_comb begin
        sel_din0 = '0;
        sel_din1 = '0;
        gnt_idx  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rr_grant[i]) begin
                sel_din0 = req_din0[i*DIN0_W +: DIN0_W];
                sel_din1 = req_din1[i*DIN1_W +: DIN1_W];
                gnt_idx  = ID_W'(i);
            end
        end
    end

    assign ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    // Single shared multiplier; wraps modulo 2^DOUT_W.
    assign product = DOUT_W'(PROD_W'(sel_din0) * PROD_W'(sel_din1));

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state    <= S_EMPTY;
            ptr      <= '0;
            res_data <= '0;
            res_id   <= '0;
            op_count <= '0;
        end else begin
            if (xfer) begin
                op_count <= op_count + CNT_W'(1);
            end
            if (grant) begin
                state    <= S_FULL;
                ptr      <= ptr_next;
                res_data <= product;
                res_id   <= gnt_idx;
            end else if (xfer) begin
                state <= S_EMPTY;
            end
        end
    end

    assign res_valid = (state == S_FULL);
    assign busy      = (state == S_FULL);

endmodule
